// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// The state set gains CHK when LOADER_CHECKSUM_EN is defined.
package inst_loader_pkg;

  localparam int HDR_W = 16;
  localparam logic [15:0] NOP_WORD = 16'h0800;
  localparam logic [15:0] DEF_BASE_ADDR = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DAT_LO,
    S_DAT_HI,
    S_WRITE
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CHK
`endif
  } state_e;

endpackage

// File: rtl/inst_loader_pair.sv
// Low/high byte register pair shared by the count header and data words.
// pair_o pulses the cycle after the high byte lands, with word_o complete.
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        lo_we_i,
  input  logic        hi_we_i,
  input  logic [7:0]  byte_i,
  output logic [7:0]  lo_o,
  output logic [15:0] word_o,
  output logic        pair_o
);

  logic [7:0] lo_q;
  logic [7:0] hi_q;
  logic       pair_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q   <= '0;
      hi_q   <= '0;
      pair_q <= 1'b0;
    end else begin
      pair_q <= hi_we_i;
      if (clr_i) begin
        lo_q <= '0;
        hi_q <= '0;
      end
      if (lo_we_i) lo_q <= byte_i;
      if (hi_we_i) hi_q <= byte_i;
    end
  end

  assign lo_o   = lo_q;
  assign word_o = {hi_q, lo_q};
  assign pair_o = pair_q;

endmodule

// File: rtl/inst_loader.sv
// Boot loader: UART byte stream -> instruction memory, CPU held meanwhile.
// LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned       MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded,
  output logic              cpu_hold
);

  localparam logic [HDR_W-1:0] MAX_CNT = HDR_W'(MAX_WORDS);

  state_e            state_q;
  logic              rx_ready_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic [15:0]       words_q;
  logic [15:0]       words_d;
  logic [HDR_W-1:0]  count_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic        acc;
  logic        lo_we;
  logic        hi_we;
  logic        clr;
  logic [7:0]  asm_lo;
  logic [15:0] asm_word;
  logic        asm_pair;

  assign acc   = rx_valid && rx_ready_q;
  assign lo_we = acc && (state_q == S_CNT_LO || state_q == S_DAT_LO);
  assign hi_we = acc && (state_q == S_CNT_HI || state_q == S_DAT_HI);
  assign clr   = start && (state_q == S_IDLE);
  assign words_d = words_q + 16'd1;

  byte_pair_assembler u_pair (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .lo_we_i (lo_we),
    .hi_we_i (hi_we),
    .byte_i  (rx_data),
    .lo_o    (asm_lo),
    .word_o  (asm_word),
    .pair_o  (asm_pair)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      words_q     <= '0;
      count_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_CNT_LO;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
            mem_addr_q <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        S_CNT_LO: begin
          if (acc) state_q <= S_CNT_HI;
        end
        S_CNT_HI: begin
          // header is judged once the assembler reports the full pair
          if (acc) begin
            rx_ready_q <= 1'b0;
          end else if (asm_pair) begin
            count_q <= asm_word;
            if (asm_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q    <= S_CHK;
              rx_ready_q <= 1'b1;
`else
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else if (asm_word > MAX_CNT) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q    <= S_DAT_LO;
              rx_ready_q <= 1'b1;
            end
          end
        end
        S_DAT_LO: begin
          if (acc) begin
            state_q <= S_DAT_HI;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_q ^ rx_data;
`endif
          end
        end
        S_DAT_HI: begin
          if (acc) begin
            state_q     <= S_WRITE;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= {rx_data, asm_lo};
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_q ^ rx_data;
`endif
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            words_q    <= words_d;
            if (words_d == count_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_q    <= S_CHK;
              rx_ready_q <= 1'b1;
`else
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q    <= S_DAT_LO;
              rx_ready_q <= 1'b1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (acc) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= (rx_data == csum_q);
            error_q    <= (rx_data != csum_q);
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;
  assign cpu_hold     = busy_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: random byte streams, stalling memory.
// Expected writes/status come from a stream-level model of the load rules.
module tb_inst_loader;

  localparam int MAXW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic        cpu_hold;

  inst_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .cpu_hold     (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic        ok;
    logic        err;
    logic [15:0] words;
  } st_t;

  wr_t         wq[$];
  st_t         sq[$];
  logic [7:0]  stm[$];
  logic [15:0] wbuf[$];

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;
  int gap_max = 0;
  int wcnt = 0;
  int busy_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory: acks ack_delay cycles after it first sees mem_we
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_we) begin
      if (wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk) if (busy) busy_cyc++;

  logic        prev_busy = 1'b0;
  logic        prev_we = 1'b0;
  logic        prev_ack = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_busy = 1'b0;
      prev_we = 1'b0;
      prev_ack = 1'b0;
    end else begin
      chk("cpu_hold_eq_busy", cpu_hold, busy);
      if (mem_we) begin
        chk("rx_ready_in_write", rx_ready, 0);
        if (prev_we && !prev_ack) begin
          chk("addr_stable", mem_addr, prev_addr);
          chk("wdata_stable", mem_wdata, prev_data);
        end
        if (mem_ack) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h, none required",
                     mem_addr, mem_wdata);
          end else begin
            wr_t w;
            w = wq.pop_front();
            chk("write_addr", mem_addr, w.addr);
            chk("write_data", mem_wdata, w.data);
          end
        end
      end
      if (prev_busy && !busy) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: load ended, none required");
        end else begin
          st_t s;
          s = sq.pop_front();
          chk("done", done, s.ok);
          chk("error", error, s.err);
          chk("words_loaded", words_loaded, s.words);
        end
      end
      prev_busy = busy;
      prev_we = mem_we;
      prev_ack = mem_ack;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  task automatic build_stream(input int cnt, input bit good);
    logic [7:0] x;
    x = 8'h00;
    stm.delete();
    stm.push_back(8'(cnt));
    stm.push_back(8'(cnt >> 8));
    if (cnt <= MAXW) begin
      for (int i = 0; i < cnt; i++) begin
        stm.push_back(wbuf[i][7:0]);
        stm.push_back(wbuf[i][15:8]);
        x = x ^ wbuf[i][7:0] ^ wbuf[i][15:8];
      end
`ifdef LOADER_CHECKSUM_EN
      stm.push_back(good ? x : (x ^ 8'h01));
`else
      if (!good) x = 8'h00;
`endif
    end
  endtask

  // reads the byte stream the way the loader is meant to
  task automatic model();
    int         cnt;
    logic [7:0] x;
    bit         ok;
    st_t        s;
    cnt = int'({stm[1], stm[0]});
    x = 8'h00;
    ok = 1'b1;
    if (cnt > MAXW) begin
      s = '{ok: 1'b0, err: 1'b1, words: 16'd0};
    end else begin
      for (int i = 0; i < cnt; i++) begin
        wq.push_back('{addr: 16'(i), data: {stm[3 + 2*i], stm[2 + 2*i]}});
        x = x ^ stm[2 + 2*i] ^ stm[3 + 2*i];
      end
`ifdef LOADER_CHECKSUM_EN
      ok = (stm[2 + 2*cnt] == x);
`endif
      s = '{ok: ok, err: !ok, words: 16'(cnt)};
    end
    sq.push_back(s);
  endtask

  task automatic pulse_start(input logic [7:0] first);
    @(negedge clk);
    rx_data = first;
    rx_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    int g;
    n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: rx_ready=0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
    if (gap_max > 0) begin
      g = $urandom_range(0, gap_max);
      rx_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", n);
    end
    @(negedge clk);
    chk("writes_pending", wq.size(), 0);
    chk("status_pending", sq.size(), 0);
    chk("rx_ready_idle", rx_ready, 0);
  endtask

  task automatic run_stream();
    model();
    busy_cyc = 0;
    pulse_start(stm[0]);
    foreach (stm[i]) send_byte(stm[i]);
    rx_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    mem_ack = 1'b0;
    #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_words", words_loaded, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    wbuf = '{16'h4907, 16'h0800};
    build_stream(2, 1'b1);
    run_stream();

    build_stream(0, 1'b1);
    run_stream();
`ifdef LOADER_CHECKSUM_EN
    chk("busy_cycles_zero", busy_cyc, 4);
`else
    chk("busy_cycles_zero", busy_cyc, 3);
`endif

    build_stream(65, 1'b1);
    run_stream();

    ack_delay = 5;
    wbuf = '{16'h1234, 16'hABCD, 16'h0800};
    build_stream(3, 1'b1);
    run_stream();
    ack_delay = 0;

    wbuf = '{16'h4907, 16'h0800};
    build_stream(2, 1'b1);
    model();
    pulse_start(stm[0]);
    for (int i = 0; i < 5; i++) send_byte(stm[i]);
    rst = 1'b0;
    #1;
    chk("mid_rx_ready", rx_ready, 0);
    chk("mid_mem_we", mem_we, 0);
    chk("mid_busy", busy, 0);
    chk("mid_cpu_hold", cpu_hold, 0);
    chk("mid_done", done, 0);
    chk("mid_error", error, 0);
    chk("mid_mem_addr", mem_addr, 0);
    chk("mid_mem_wdata", mem_wdata, 0);
    chk("mid_words", words_loaded, 0);
    chk("mid_unwritten", wq.size(), 1);
    wq.delete();
    sq.delete();
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wbuf = '{16'h0BAD, 16'h0800};
    build_stream(2, 1'b1);
    run_stream();

`ifdef LOADER_CHECKSUM_EN
    wbuf = '{16'h4907, 16'h0800};
    build_stream(2, 1'b1);
    run_stream();
    build_stream(2, 1'b0);
    run_stream();
`endif

    for (int t = 0; t < 10; t++) begin
      int cnt;
      cnt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(65, 300))
                                         : int'($urandom_range(0, 8));
      wbuf.delete();
      for (int i = 0; i < cnt && i < MAXW; i++)
        wbuf.push_back(($urandom_range(0, 3) == 0) ? 16'h0800
                                                   : 16'($urandom));
      ack_delay = $urandom_range(0, 3);
      gap_max = $urandom_range(0, 2);
      build_stream(cnt, $urandom_range(0, 2) != 0);
      run_stream();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
